pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered program-counter controller for the 8-bit core.
- Holds the PC and applies the core's next-address rules on each instruction-complete pulse: sequential, unconditional jump, X-conditional jump, and jump-indirect (JDI).
- Runs the memory handshake that fetches a JDI target.
- Owns interrupt entry (forced vector) and return (RETI), including the saved return address.

Parameters:
- AW, 8, PC/address width.
- RESET_VEC, 8'h00, PC value loaded on reset.
- INT_VEC, 8'hF0, PC forced on interrupt entry.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- step  in  1  one-cycle pulse: current instruction done; sample controls, advance PC.
- jump_src  in  1  0: sequential; 1: jump instruction.
- jcond  in  1  0: unconditional jump; 1: conditional on x_in.
- x_in  in  1  condition flag; 1 = take conditional jump.
- is_jdi  in  1  unconditional jump is indirect via memory.
- address  in  AW  jump target, or JDI pointer when is_jdi=1.
- jdi_req  out  1  request indirect-target read at jdi_addr.
- jdi_addr  out  AW  pointer for the JDI read.
- jdi_ack  in  1  read data valid this cycle.
- jdi_data  in  AW  indirect jump target.
- irq  in  1  level interrupt request.
- int_en  in  1  global interrupt enable.
- reti  in  1  current instruction is return-from-interrupt.
- pc  out  AW  current program counter.
- pc_valid  out  1  pc is valid for fetch.
- epc  out  AW  saved return address.
- in_isr  out  1  handler active.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, pc_valid=0, jdi_req=0, jdi_addr=0, epc=0, in_isr=0, state=BOOT. Reset asserted mid-JDI aborts the read immediately; jdi_req drops asynchronously.
- States: BOOT, RUN, JDI_WAIT.
- BOOT -> RUN after exactly one clock; pc_valid=1 from that edge.
- RUN, step=0: hold all registers.
- Sequential address: seq = pc+1 mod 2^AW (8'hFF wraps to 8'h00).
- Normal next address nx:
  - jump_src=0: nx=seq.
  - jump_src=1, jcond=1: nx = x_in ? address : seq.
  - jump_src=1, jcond=0, is_jdi=0: nx=address.
- RUN, step=1 — priority, highest first:
  1. JDI (jump_src=1, jcond=0, is_jdi=1): jdi_req=1, jdi_addr=address, pc_valid=0, go to JDI_WAIT. pc holds. irq is not taken on this step.
  2. Interrupt (irq & int_en & !in_isr): epc=nx, pc=INT_VEC, in_isr=1.
  3. Return (reti & in_isr): pc=epc, in_isr=0.
  4. Otherwise: pc=nx. This includes reti with in_isr=0, which is treated as an ordinary instruction.
- Latency: new pc visible the cycle after the step edge.
- JDI_WAIT:
  - jdi_req and jdi_addr held stable until jdi_ack. There is no timeout.
  - On jdi_ack=1: pc=jdi_data, jdi_req=0, pc_valid=1, go to RUN.
  - jdi_ack in the same cycle jdi_req first rises is accepted only in JDI_WAIT, i.e. from the next edge on.
  - step pulses in JDI_WAIT are ignored.
  - irq is re-evaluated at the next step after return to RUN.
- jdi_ack outside JDI_WAIT: ignored.
- Nested interrupts: irq while in_isr=1 is ignored (no epc overwrite).
- epc changes only on interrupt entry.

Test Plan:
- Reset, then 3 step pulses with jump_src=0 -> pc 00, 01, 02, 03; pc_valid 0 in BOOT cycle, then 1. Preload pc=FE and step twice -> FF, 00.
- Conditional jump: pc=10, jump_src=1, jcond=1, address=40. With x_in=0 -> pc=11. Repeat at pc=11 with x_in=1 -> pc=40.
- JDI: pc=20, jump_src=1, jcond=0, is_jdi=1, address=80 -> jdi_req=1, jdi_addr=80, pc_valid=0. Hold jdi_ack=0 for 4 cycles with 2 extra step pulses -> pc stays 20. Then ack with jdi_data=5A -> pc=5A, pc_valid=1, jdi_req=0.
- Interrupt: pc=30, irq=1, int_en=1, sequential step -> pc=F0, epc=31, in_isr=1. Further irq steps -> pc=F1, F2, epc=31. Step with reti=1 -> pc=31, in_isr=0.
- Interrupt vs jump: pc=30, irq=1, jump_src=1, jcond=0, is_jdi=0, address=60 -> epc=60, pc=F0. irq with int_en=0 -> no entry. irq with a JDI step -> JDI handshake first, interrupt taken on the following step.
- Mid-JDI reset: in JDI_WAIT, drop rst_n -> jdi_req=0, pc=00, in_isr=0 immediately. Late jdi_ack after reset is ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, JDI fetch handshake, interrupt entry/return.
// Ports: step/jump_src/jcond/x_in/is_jdi/address select the next pc;
//   jdi_req/jdi_addr/jdi_ack/jdi_data fetch an indirect jump target;
//   irq/int_en/reti drive interrupt entry and return;
//   pc/pc_valid give the fetch address, epc/in_isr the handler state.
module pc_sequencer #(
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_VEC = AW'(8'h00),
  parameter logic [AW-1:0] INT_VEC = AW'(8'hF0)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          jump_src,
  input  logic          jcond,
  input  logic          x_in,
  input  logic          is_jdi,
  input  logic [AW-1:0] address,
  output logic          jdi_req,
  output logic [AW-1:0] jdi_addr,
  input  logic          jdi_ack,
  input  logic [AW-1:0] jdi_data,
  input  logic          irq,
  input  logic          int_en,
  input  logic          reti,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic [AW-1:0] epc,
  output logic          in_isr
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    JDI_WAIT
  } state_t;

  state_t state;

  logic [AW-1:0] seq;
  logic [AW-1:0] nx;
  logic          do_jdi;
  logic          do_int;
  logic          do_ret;
  logic          do_nx;

  always_comb begin
    seq = pc + AW'(1);
    nx  = seq;
    unique case (1'b1)
      !jump_src:        nx = seq;
      jump_src & jcond: nx = x_in ? address : seq;
      default:          nx = address;
    endcase
  end

  // One-hot step action, highest priority first.
  // A JDI step masks the interrupt; it is seen
  // again on the first step back in RUN.
  always_comb begin
    do_jdi = step & jump_src & ~jcond & is_jdi;
    do_int = step & ~do_jdi & irq & int_en
           & ~in_isr;
    do_ret = step & ~do_jdi & ~do_int
           & reti & in_isr;
    do_nx  = step & ~do_jdi & ~do_int & ~do_ret;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      jdi_req  <= 1'b0;
      jdi_addr <= '0;
      epc      <= '0;
      in_isr   <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          unique case (1'b1)
            do_jdi: begin
              state    <= JDI_WAIT;
              jdi_req  <= 1'b1;
              jdi_addr <= address;
              pc_valid <= 1'b0;
            end
            do_int: begin
              epc    <= nx;
              pc     <= INT_VEC;
              in_isr <= 1'b1;
            end
            do_ret: begin
              pc     <= epc;
              in_isr <= 1'b0;
            end
            do_nx: begin
              pc <= nx;
            end
            default: ;
          endcase
        end
        JDI_WAIT: begin
          if (jdi_ack) begin
            state    <= RUN;
            pc       <= jdi_data;
            jdi_req  <= 1'b0;
            pc_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, hand sequences and
// randomized run against a next-pc reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step, jump_src, jcond, x_in, is_jdi;
  logic [7:0] address;
  logic       jdi_req;
  logic [7:0] jdi_addr;
  logic       jdi_ack;
  logic [7:0] jdi_data;
  logic       irq, int_en, reti;
  logic [7:0] pc;
  logic       pc_valid;
  logic [7:0] epc;
  logic       in_isr;

  int tests = 0;
  int fails = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step(step),
    .jump_src(jump_src), .jcond(jcond),
    .x_in(x_in), .is_jdi(is_jdi),
    .address(address), .jdi_req(jdi_req),
    .jdi_addr(jdi_addr), .jdi_ack(jdi_ack),
    .jdi_data(jdi_data), .irq(irq),
    .int_en(int_en), .reti(reti), .pc(pc),
    .pc_valid(pc_valid), .epc(epc),
    .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, js, jc, x, jd;
    logic [7:0] addr;
    logic       ack;
    logic [7:0] data;
    logic       irq, ien, reti;
    logic [7:0] pc;
    logic       v, req;
    logic [7:0] ja, epc;
    logic       isr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic st, js, jc, x, jd,
    input logic [7:0] addr,
    input logic ack,
    input logic [7:0] data,
    input logic irq_i, ien, rt,
    input logic [7:0] epc_pc,
    input logic v, req,
    input logic [7:0] ja, ep,
    input logic isr
  );
    vec_t r;
    r.st = st; r.js = js; r.jc = jc;
    r.x = x; r.jd = jd; r.addr = addr;
    r.ack = ack; r.data = data;
    r.irq = irq_i; r.ien = ien; r.reti = rt;
    r.pc = epc_pc; r.v = v; r.req = req;
    r.ja = ja; r.epc = ep; r.isr = isr;
    tbl.push_back(r);
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference model: mode 0 boot, 1 run, 2 waiting
  // for the indirect target.
  int m_mode;
  int m_pc, m_epc, m_ja;
  bit m_isr, m_valid, m_req;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_epc = 0; m_ja = 0;
    m_isr = 0; m_valid = 0; m_req = 0;
  endtask

  task automatic model_edge();
    int target;
    if (m_mode == 0) begin
      m_mode = 1;
      m_valid = 1;
    end else if (m_mode == 2) begin
      if (jdi_ack) begin
        m_pc = int'(jdi_data);
        m_req = 0;
        m_valid = 1;
        m_mode = 1;
      end
    end else if (step) begin
      target = (m_pc + 1) % 256;
      if (jump_src && (!jcond || x_in))
        target = int'(address);
      if (jump_src && !jcond && is_jdi) begin
        m_req = 1;
        m_ja = int'(address);
        m_valid = 0;
        m_mode = 2;
      end else if (irq && int_en && !m_isr) begin
        m_epc = target;
        m_pc = 'hF0;
        m_isr = 1;
      end else if (reti && m_isr) begin
        m_pc = m_epc;
        m_isr = 0;
      end else begin
        m_pc = target;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    step = 0; jump_src = 0; jcond = 0; x_in = 0;
    is_jdi = 0; address = 0; jdi_ack = 0;
    jdi_data = 0; irq = 0; int_en = 0; reti = 0;
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // st js jc x jd addr ack data irq ien reti
    //   pc v req ja epc isr
    add(0,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h00,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h01,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h02,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h03,1,0,8'h00,8'h00,0);
    add(1,1,0,0,0,8'hFE,0,8'h00,0,0,0, 8'hFE,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'hFF,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h00,1,0,8'h00,8'h00,0);
    add(1,1,0,0,0,8'h10,0,8'h00,0,0,0, 8'h10,1,0,8'h00,8'h00,0);
    add(1,1,1,0,0,8'h40,0,8'h00,0,0,0, 8'h11,1,0,8'h00,8'h00,0);
    add(1,1,1,1,0,8'h40,0,8'h00,0,0,0, 8'h40,1,0,8'h00,8'h00,0);
    add(1,1,0,0,0,8'h20,0,8'h00,0,0,0, 8'h20,1,0,8'h00,8'h00,0);
    add(1,1,0,0,1,8'h80,0,8'h00,0,0,0, 8'h20,0,1,8'h80,8'h00,0);
    add(0,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h20,0,1,8'h80,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h20,0,1,8'h80,8'h00,0);
    add(0,0,0,0,0,8'h00,0,8'h00,0,0,0, 8'h20,0,1,8'h80,8'h00,0);
    add(1,1,0,0,0,8'h33,0,8'h00,0,0,0, 8'h20,0,1,8'h80,8'h00,0);
    add(0,0,0,0,0,8'h00,1,8'h5A,0,0,0, 8'h5A,1,0,8'h00,8'h00,0);
    add(1,1,0,0,0,8'h30,0,8'h00,0,0,0, 8'h30,1,0,8'h00,8'h00,0);
    add(1,0,0,0,0,8'h00,0,8'h00,1,1,0, 8'hF0,1,0,8'h00,8'h31,1);
    add(1,0,0,0,0,8'h00,0,8'h00,1,1,0, 8'hF1,1,0,8'h00,8'h31,1);
    add(1,0,0,0,0,8'h00,0,8'h00,1,1,0, 8'hF2,1,0,8'h00,8'h31,1);
    add(1,0,0,0,0,8'h00,0,8'h00,1,1,1, 8'h31,1,0,8'h00,8'h31,0);
    add(1,1,0,0,0,8'h30,0,8'h00,0,0,0, 8'h30,1,0,8'h00,8'h31,0);
    add(1,1,0,0,0,8'h60,0,8'h00,1,1,0, 8'hF0,1,0,8'h00,8'h60,1);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,1, 8'h60,1,0,8'h00,8'h60,0);
    add(1,0,0,0,0,8'h00,0,8'h00,1,0,0, 8'h61,1,0,8'h00,8'h60,0);
    add(1,1,0,0,1,8'h90,0,8'h00,1,1,0, 8'h61,0,1,8'h90,8'h60,0);
    add(0,0,0,0,0,8'h00,1,8'h70,1,1,0, 8'h70,1,0,8'h00,8'h60,0);
    add(1,0,0,0,0,8'h00,0,8'h00,1,1,0, 8'hF0,1,0,8'h00,8'h71,1);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,1, 8'h71,1,0,8'h00,8'h71,0);
    add(1,0,0,0,0,8'h00,0,8'h00,0,0,1, 8'h72,1,0,8'h00,8'h71,0);
    add(0,0,0,0,0,8'h00,1,8'h99,0,0,0, 8'h72,1,0,8'h00,8'h71,0);
    add(1,1,0,0,1,8'h44,1,8'h55,0,0,0, 8'h72,0,1,8'h44,8'h71,0);
    add(0,0,0,0,0,8'h00,1,8'h55,0,0,0, 8'h55,1,0,8'h00,8'h71,0);

    // Reset state, including pc_valid low in BOOT.
    #12;
    chk("rst pc", pc, 8'h00);
    chk("rst pc_valid", pc_valid, 1'b0);
    chk("rst jdi_req", jdi_req, 1'b0);
    chk("rst jdi_addr", jdi_addr, 8'h00);
    chk("rst epc", epc, 8'h00);
    chk("rst in_isr", in_isr, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("boot pc_valid", pc_valid, 1'b0);

    foreach (tbl[i]) begin
      r = tbl[i];
      step = r.st; jump_src = r.js; jcond = r.jc;
      x_in = r.x; is_jdi = r.jd; address = r.addr;
      jdi_ack = r.ack; jdi_data = r.data;
      irq = r.irq; int_en = r.ien; reti = r.reti;
      tick();
      chk($sformatf("row%0d pc", i), pc, r.pc);
      chk($sformatf("row%0d pc_valid", i),
          pc_valid, r.v);
      chk($sformatf("row%0d jdi_req", i),
          jdi_req, r.req);
      if (r.req)
        chk($sformatf("row%0d jdi_addr", i),
            jdi_addr, r.ja);
      chk($sformatf("row%0d epc", i), epc, r.epc);
      chk($sformatf("row%0d in_isr", i),
          in_isr, r.isr);
    end

    // Reset while waiting on a JDI read inside a handler.
    idle_inputs();
    step = 1; irq = 1; int_en = 1;
    tick();
    chk("mid isr entry", in_isr, 1'b1);
    idle_inputs();
    step = 1; jump_src = 1; is_jdi = 1;
    address = 8'h80;
    tick();
    chk("mid jdi_req", jdi_req, 1'b1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async jdi_req", jdi_req, 1'b0);
    chk("async pc", pc, 8'h00);
    chk("async in_isr", in_isr, 1'b0);
    chk("async pc_valid", pc_valid, 1'b0);
    chk("async epc", epc, 8'h00);
    model_reset();
    jdi_ack = 1; jdi_data = 8'hAB;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("late ack pc", pc, 8'h00);
    chk("late ack valid", pc_valid, 1'b1);
    chk("late ack req", jdi_req, 1'b0);
    tick();
    chk("late ack pc2", pc, 8'h00);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      step = ($urandom_range(0, 1) == 1);
      jump_src = ($urandom_range(0, 2) == 0);
      jcond = $urandom_range(0, 1) == 1;
      x_in = $urandom_range(0, 1) == 1;
      is_jdi = ($urandom_range(0, 2) == 0);
      address = 8'($urandom);
      jdi_ack = ($urandom_range(0, 2) == 0);
      jdi_data = 8'($urandom);
      irq = ($urandom_range(0, 3) == 0);
      int_en = $urandom_range(0, 1) == 1;
      reti = ($urandom_range(0, 2) == 0);
      tick();
      chk("rnd pc", pc, 8'(m_pc));
      chk("rnd pc_valid", pc_valid, m_valid);
      chk("rnd jdi_req", jdi_req, m_req);
      if (m_req)
        chk("rnd jdi_addr", jdi_addr, 8'(m_ja));
      chk("rnd epc", epc, 8'(m_epc));
      chk("rnd in_isr", in_isr, m_isr);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
